// File: rtl/bus_dma_copy_if.sv
// Bus bundle for bus_dma_copy: peripheral-style config port plus the
// initiator port onto the picoRV memory bus.
interface bus_dma_copy_if;
  logic        select;
  logic [3:0]  wstrb;
  logic [3:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic        irq;

  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  // slave: the DMA engine's view (config target, memory initiator)
  modport slave (
    input  select, wstrb, addr, data_i, m_ready, m_rdata,
    output ready, data_o, irq, m_valid, m_addr, m_wdata, m_wstrb
  );

  // master: the CPU/interconnect/memory side
  modport master (
    output select, wstrb, addr, data_i, m_ready, m_rdata,
    input  ready, data_o, irq, m_valid, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/bus_dma_copy.sv
// Single-channel word-copy DMA: CPU-programmed SRC/DST/LEN, read-then-write
// beats on the master port, level irq on completion.
module bus_dma_copy #(
  parameter int unsigned LEN_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  bus_dma_copy_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t            state, state_n;
  logic              armed;
  logic              acc, wr_en, wr_ctrl, wr_src, wr_dst, wr_len;
  logic              busy, beat_done, start_cmd, abort_cmd;
  logic [31:0]       src, dst, rd_val;
  logic [LEN_W-1:0]  len, len_dec;
  logic              irq_en, done, abort_pend;
  logic              unused_addr;

  assign unused_addr = ^bus.addr[1:0];

  assign acc       = bus.select && armed;
  assign wr_en     = acc && (|bus.wstrb);
  assign wr_ctrl   = wr_en && (bus.addr[3:2] == 2'd0);
  assign wr_src    = wr_en && (bus.addr[3:2] == 2'd1);
  assign wr_dst    = wr_en && (bus.addr[3:2] == 2'd2);
  assign wr_len    = wr_en && (bus.addr[3:2] == 2'd3);
  assign busy      = (state == RD) || (state == WR);
  assign beat_done = bus.m_valid && bus.m_ready;
  assign start_cmd = wr_ctrl && bus.data_i[0] && !busy;
  assign abort_cmd = wr_ctrl && bus.data_i[4] && busy;
  assign len_dec   = len - 1'b1;
  assign bus.irq   = done && irq_en;

  always_comb begin
    rd_val = '0;
    case (bus.addr[3:2])
      2'd0:    rd_val = {28'd0, done, busy, irq_en, 1'b0};
      2'd1:    rd_val = src;
      2'd2:    rd_val = dst;
      default: rd_val = 32'(len);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start_cmd) state_n = (len == '0) ? FIN : RD;
      RD:   if (beat_done) state_n = WR;
      WR: begin
        if (beat_done) begin
          if (abort_pend || abort_cmd) state_n = IDLE;
          else if (len_dec == '0)      state_n = FIN;
          else                         state_n = RD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed       <= 1'b0;
      bus.ready   <= 1'b0;
      bus.data_o  <= '0;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      abort_pend  <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
    end else begin
      bus.ready  <= acc;
      bus.data_o <= acc ? rd_val : '0;
      if (!bus.select) armed <= 1'b1;
      else if (acc)    armed <= 1'b0;

      // slave write first, FIN afterwards: a W1C in the FIN cycle loses
      if (wr_ctrl) begin
        irq_en <= bus.data_i[1];
        if (bus.data_i[3]) done <= 1'b0;
      end
      if (state == FIN) done <= 1'b1;

      if (state == IDLE)  abort_pend <= 1'b0;
      else if (abort_cmd) abort_pend <= 1'b1;

      if (wr_src && !busy)                src <= {bus.data_i[31:2], 2'b00};
      else if (state == RD && beat_done)  src <= src + 32'd4;
      if (wr_dst && !busy)                dst <= {bus.data_i[31:2], 2'b00};
      else if (state == WR && beat_done)  dst <= dst + 32'd4;
      if (wr_len && !busy)                len <= bus.data_i[LEN_W-1:0];
      else if (state == WR && beat_done)  len <= len_dec;

      if (state == RD && beat_done) bus.m_wdata <= bus.m_rdata;

      // request is launched from the registered state, so every beat is
      // preceded by one cycle with m_valid low
      if (bus.m_valid) begin
        if (bus.m_ready) bus.m_valid <= 1'b0;
      end else if (busy) begin
        bus.m_valid <= 1'b1;
        bus.m_addr  <= (state == WR) ? dst : src;
        bus.m_wstrb <= (state == WR) ? 4'hF : 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_bus_dma_copy.sv
// Self-checking bench for bus_dma_copy: register table, memory model with a
// beat scoreboard, and hand-written copy/abort/reset sequences.
module tb_bus_dma_copy;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bus_dma_copy_if bus ();

  bus_dma_copy #(.LEN_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    bit          we;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  beat_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    beats    = 0;
  int    lat      = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // memory: m_ready two cycles after m_valid, beats checked against scoreboard
  always @(negedge clk) begin
    beat_t e;
    if (!reset_n) begin
      bus.m_ready = 1'b0;
      lat = 0;
    end else if (bus.m_ready) begin
      bus.m_ready = 1'b0;
      lat = 0;
      check("m_valid_drop", {31'd0, bus.m_valid}, 32'd0);
    end else if (bus.m_valid) begin
      lat++;
      if (lat == 2) begin
        beats++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: beat addr=0x%08h wstrb=%h, required no beat", bus.m_addr, bus.m_wstrb);
        end else begin
          e = sb.pop_front();
          check("beat_addr", bus.m_addr, e.addr);
          check("beat_wstrb", {28'd0, bus.m_wstrb}, e.we ? 32'hF : 32'h0);
          if (e.we) check("beat_wdata", bus.m_wdata, e.data);
        end
        bus.m_rdata = pat(bus.m_addr);
        bus.m_ready = 1'b1;
      end
    end else begin
      lat = 0;
    end
  end

  task automatic access(input bit we, input logic [3:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
    int n;
    n = 0;
    bus.select = 1'b1;
    bus.wstrb  = we ? 4'hF : 4'h0;
    bus.addr   = a;
    bus.data_i = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 8);
    if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
    rd = bus.data_o;
    bus.select = 1'b0;
    bus.wstrb  = 4'h0;
    bus.data_i = '0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    access(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    access(1'b0, a, 32'd0, v);
    check(nm, v, exp);
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{1'b0, s + 32'(4 * i), pat(s + 32'(4 * i))});
      sb.push_back('{1'b1, d + 32'(4 * i), pat(s + 32'(4 * i))});
    end
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[14];
    int   b0, n;

    vt[0]  = '{0, 4'h0, 32'h0,         32'h0};
    vt[1]  = '{0, 4'h4, 32'h0,         32'h0};
    vt[2]  = '{0, 4'h8, 32'h0,         32'h0};
    vt[3]  = '{0, 4'hC, 32'h0,         32'h0};
    vt[4]  = '{1, 4'h4, 32'h0000_0103, 32'h0};
    vt[5]  = '{0, 4'h4, 32'h0,         32'h0000_0100};
    vt[6]  = '{1, 4'h8, 32'hABCD_0007, 32'h0};
    vt[7]  = '{0, 4'h8, 32'h0,         32'hABCD_0004};
    vt[8]  = '{1, 4'hC, 32'h0001_2345, 32'h0};
    vt[9]  = '{0, 4'hC, 32'h0,         32'h0000_2345};
    vt[10] = '{1, 4'h0, 32'h0000_0012, 32'h0};
    vt[11] = '{0, 4'h0, 32'h0,         32'h0000_0002};
    vt[12] = '{1, 4'h0, 32'h0000_0008, 32'h0};
    vt[13] = '{0, 4'h0, 32'h0,         32'h0};

    reset_n     = 1'b0;
    bus.select  = 1'b0;
    bus.wstrb   = 4'h0;
    bus.addr    = 4'h0;
    bus.data_i  = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready",   {31'd0, bus.ready},   32'd0);
    check("rst_data_o",  bus.data_o,           32'd0);
    check("rst_irq",     {31'd0, bus.irq},     32'd0);
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_addr",  bus.m_addr,           32'd0);
    check("rst_m_wdata", bus.m_wdata,          32'd0);
    check("rst_m_wstrb", {28'd0, bus.m_wstrb}, 32'd0);

    // ready: one cycle after select, single pulse even while select is held
    bus.select = 1'b1;
    bus.wstrb  = 4'hF;
    bus.addr   = 4'h4;
    bus.data_i = 32'h0000_0103;
    check("ready_pre", {31'd0, bus.ready}, 32'd0);
    @(negedge clk);
    check("ready_rise", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    check("ready_pulse", {31'd0, bus.ready}, 32'd0);
    check("data_o_idle", bus.data_o, 32'd0);
    @(negedge clk);
    check("ready_hold", {31'd0, bus.ready}, 32'd0);
    bus.select = 1'b0;
    bus.wstrb  = 4'h0;
    @(negedge clk);
    rd_chk("src_mask", 4'h4, 32'h0000_0100);

    // basic copy of three words
    wr(4'h4, 32'h0000_1000);
    wr(4'h8, 32'h0000_2000);
    wr(4'hC, 32'd3);
    push_copy(32'h1000, 32'h2000, 3);
    wr(4'h0, 32'h3);
    wait_drain(300);
    rd_chk("copy_ctrl", 4'h0, 32'h0000_000A);
    rd_chk("copy_src",  4'h4, 32'h0000_100C);
    rd_chk("copy_dst",  4'h8, 32'h0000_200C);
    rd_chk("copy_len",  4'hC, 32'h0);
    check("copy_irq", {31'd0, bus.irq}, 32'd1);

    // irq follows IRQ_EN with DONE held
    wr(4'h0, 32'h0);
    check("irq_en_off", {31'd0, bus.irq}, 32'd0);
    wr(4'h0, 32'h2);
    check("irq_en_on", {31'd0, bus.irq}, 32'd1);

    // LEN=0 start: no traffic, DONE shortly after
    wr(4'h0, 32'hA);
    check("w1c_irq", {31'd0, bus.irq}, 32'd0);
    b0 = beats;
    wr(4'h0, 32'h3);
    check("len0_done_irq", {31'd0, bus.irq}, 32'd1);
    repeat (6) @(negedge clk);
    check("len0_nobeat", 32'(beats), 32'(b0));
    wr(4'h0, 32'h8);
    check("len0_clr_irq", {31'd0, bus.irq}, 32'd0);
    rd_chk("len0_ctrl", 4'h0, 32'h0);

    // abort during the second read of a four-word copy
    wr(4'h4, 32'h0000_3000);
    wr(4'h8, 32'h0000_4000);
    wr(4'hC, 32'd4);
    push_copy(32'h3000, 32'h4000, 2);
    b0 = beats;
    wr(4'h0, 32'h3);
    n = 0;
    while (!(bus.m_valid && bus.m_wstrb == 4'h0 && beats == b0 + 2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_sync", {31'd0, bus.m_valid}, 32'd1);
    wr(4'h0, 32'h12);
    wait_drain(200);
    repeat (10) @(negedge clk);
    check("abort_beats", 32'(beats), 32'(b0 + 4));
    rd_chk("abort_ctrl", 4'h0, 32'h0000_0002);
    rd_chk("abort_len",  4'hC, 32'd2);
    rd_chk("abort_src",  4'h4, 32'h0000_3008);
    rd_chk("abort_dst",  4'h8, 32'h0000_4008);
    check("abort_irq", {31'd0, bus.irq}, 32'd0);

    // register writes and START while busy are ignored
    wr(4'h4, 32'h0000_5000);
    wr(4'h8, 32'h0000_6000);
    wr(4'hC, 32'd3);
    push_copy(32'h5000, 32'h6000, 3);
    wr(4'h0, 32'h3);
    n = 0;
    while (!bus.m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_sync", {31'd0, bus.m_valid}, 32'd1);
    wr(4'hC, 32'd9);
    wr(4'h4, 32'h0000_7000);
    wr(4'h8, 32'h0000_7100);
    wr(4'h0, 32'h3);
    wait_drain(300);
    repeat (10) @(negedge clk);
    rd_chk("busy_len",  4'hC, 32'h0);
    rd_chk("busy_src",  4'h4, 32'h0000_500C);
    rd_chk("busy_dst",  4'h8, 32'h0000_600C);
    rd_chk("busy_ctrl", 4'h0, 32'h0000_000A);

    // source address wraps past 0xFFFFFFFC
    wr(4'h4, 32'hFFFF_FFFC);
    wr(4'h8, 32'h0000_0100);
    wr(4'hC, 32'd2);
    push_copy(32'hFFFF_FFFC, 32'h0000_0100, 2);
    wr(4'h0, 32'hB);
    wait_drain(300);
    rd_chk("wrap_src",  4'h4, 32'h0000_0004);
    rd_chk("wrap_dst",  4'h8, 32'h0000_0108);
    rd_chk("wrap_ctrl", 4'h0, 32'h0000_000A);

    // asynchronous reset in the middle of a write beat
    wr(4'h4, 32'h0000_8000);
    wr(4'h8, 32'h0000_9000);
    wr(4'hC, 32'd3);
    push_copy(32'h8000, 32'h9000, 3);
    wr(4'h0, 32'hB);
    n = 0;
    while (!(bus.m_valid && bus.m_wstrb == 4'hF) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_sync", {31'd0, bus.m_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rstmid_m_wstrb", {28'd0, bus.m_wstrb}, 32'd0);
    check("rstmid_m_addr",  bus.m_addr,           32'd0);
    check("rstmid_m_wdata", bus.m_wdata,          32'd0);
    check("rstmid_irq",     {31'd0, bus.irq},     32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // register table: post-reset zeros, masking, width, IRQ_EN/ABORT in idle
    for (int i = 0; i < 14; i++) begin
      if (vt[i].we) wr(vt[i].a, vt[i].wd);
      else          rd_chk($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
    end
    check("final_irq", {31'd0, bus.irq}, 32'd0);
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
